// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage data-memory access sequencer. Sits between the EX/MEM pipeline
// register and the data memory. Each valid load/store held in EX/MEM becomes
// exactly one req/ack transaction. The pipeline is stalled while the access
// is outstanding. Load data is lane-selected and sign/zero-extended.
//
// Ports
//   i_clock / i_reset       rising-edge clock, async active-low reset
//   i_valid                 EX/MEM holds a valid instruction
//   i_mem[2:0]              [0] read, [1] write (write wins), [2] unused
//   i_sizemem               00 byte, 01 half, 1x word
//   i_signedmem             sign-extend loads when 1
//   i_addr, i_wdata         byte address and raw store data
//   o_mem_req/we/addr/be/wdata, i_mem_ack, i_mem_rdata
//                           memory handshake (word-aligned address)
//   o_stall                 hold the upstream pipeline this cycle
//   o_rdata, o_rdata_valid  extended load result and its 1-cycle strobe
//   o_misaligned            1-cycle pulse, access rejected
//   o_timeout               1-cycle pulse, access aborted without ack
//
// DATA_WIDTH is fixed at 32 (four byte lanes).
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_sizemem,
  input  logic                  i_signedmem,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic                  o_misaligned,
  output logic                  o_timeout
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            be_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  we_q;

  logic                  reqOp;
  logic                  aligned;
  logic                  start;
  logic [3:0]            beNew;
  logic [DATA_WIDTH-1:0] wdataNew;
  logic [7:0]            laneByte;
  logic [15:0]           laneHalf;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  unused_mem2;

  assign unused_mem2 = i_mem[2];

  // Decode is gated by reset so the stall request is low while reset is
  // held, even if EX/MEM still presents a valid access.
  assign reqOp = i_reset & i_valid & (i_mem[0] | i_mem[1]);

  always_comb begin
    aligned = 1'b1;
    case (i_sizemem)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_addr[0];
      default: aligned = (i_addr[1:0] == 2'b00);
    endcase
  end

  assign start = (state_q == IDLE) & reqOp & aligned;

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    beNew    = 4'b1111;
    wdataNew = i_wdata;
    case (i_sizemem)
      2'b00: begin
        beNew    = 4'b0001 << i_addr[1:0];
        wdataNew = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        beNew    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdataNew = {2{i_wdata[15:0]}};
      end
      default: begin
        beNew    = 4'b1111;
        wdataNew = i_wdata;
      end
    endcase
  end

  // Lane select and extension of the raw read word using the latched access.
  always_comb begin
    laneByte = i_mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   laneByte = i_mem_rdata[7:0];
      2'b01:   laneByte = i_mem_rdata[15:8];
      2'b10:   laneByte = i_mem_rdata[23:16];
      default: laneByte = i_mem_rdata[31:24];
    endcase
    laneHalf = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (size_q)
      2'b00:   loadData = {{24{signed_q & laneByte[7]}}, laneByte};
      2'b01:   loadData = {{16{signed_q & laneHalf[15]}}, laneHalf};
      default: loadData = i_mem_rdata;
    endcase
  end

  // Next-state and handshake outputs. The stall is raised combinationally in
  // the IDLE cycle that starts an access so the pipeline freezes at once.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_mem_req     = 1'b0;
    o_stall       = 1'b0;
    o_rdata_valid = 1'b0;
    o_misaligned  = 1'b0;
    o_timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          o_stall = 1'b1;
          state_d = ACCESS;
        end else if (reqOp) begin
          o_misaligned = 1'b1;
        end
      end
      ACCESS: begin
        o_mem_req = 1'b1;
        o_stall   = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (i_mem_ack) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          o_timeout = 1'b1;
          state_d   = DONE;
          cnt_d     = '0;
        end
      end
      DONE: begin
        o_rdata_valid = ~we_q;
        cnt_d         = '0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access latch and load result register. A timed-out load returns zero.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (start) begin
        addr_q   <= i_addr;
        wdata_q  <= wdataNew;
        be_q     <= beNew;
        size_q   <= i_sizemem;
        signed_q <= i_signedmem;
        we_q     <= i_mem[1];
      end
      if (state_q == ACCESS && !we_q) begin
        if (i_mem_ack) begin
          rdata_q <= loadData;
        end else if (o_timeout) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_rdata     = rdata_q;

endmodule
